// File: rtl/tr_track_drive.sv
// Tracking-mode stepper drive: maps |x-x0| to a step frequency, divides it into a
// step period N and turns N into a 50% duty step square wave.
module tr_track_drive #(
  parameter int CLK_HZ = 50_000_000,
  parameter int X_W    = 36,
  parameter int N_W    = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           data_valid,
  input  logic           data_valid_trig,
  input  logic           tr_mode_enable,
  input  logic [X_W-1:0] x,
  input  logic [31:0]    x0,
  input  logic [31:0]    dx1,
  input  logic [31:0]    dx2,
  input  logic [31:0]    k,
  input  logic [31:0]    F1,
  input  logic [31:0]    F2,
  output logic           drv_step,
  output logic           drv_dir,
  output logic           drv_enable_sm,
  output logic [N_W-1:0] N
);
  localparam int E_W = X_W + 1;
  localparam int P_W = 72;
  localparam logic [31:0] N_MAX = 32'((64'd1 << N_W) - 64'd1);

  typedef enum logic {S_IDLE, S_DIV} state_t;
  state_t state, state_nx;

  logic signed [E_W-1:0] e;
  logic [E_W-1:0] a, dx1_e, dx2_e;
  logic dead, ramp, sample, start, div_last;
  logic signed [P_W-1:0] f1_x, f2_x, k_x, d_x, f_raw;
  logic [31:0] f_clamp;

  logic [4:0]  cnt;
  logic [32:0] rem, rem_nx, shifted;
  logic [31:0] quo, quo_nx, dvsr;
  logic [33:0] trial;

  logic [N_W-1:0] n_act, counter;
  logic en_act, run;

  // Error and magnitude; x is unsigned, x0 signed, both widened to E_W
  assign e     = $signed({1'b0, x}) - $signed({{(E_W-32){x0[31]}}, x0});
  assign a     = e[E_W-1] ? $unsigned(-e) : $unsigned(e);
  assign dx1_e = {{(E_W-32){1'b0}}, dx1};
  assign dx2_e = {{(E_W-32){1'b0}}, dx2};
  assign dead  = a < dx1_e;
  assign ramp  = a < dx2_e;

  always_comb begin
    f1_x = $signed({{(P_W-32){F1[31]}}, F1});
    f2_x = $signed({{(P_W-32){F2[31]}}, F2});
    k_x  = $signed({{(P_W-32){k[31]}}, k});
    d_x  = $signed({{(P_W-E_W){1'b0}}, a - dx1_e});
    f_raw = ramp ? (f1_x + k_x * d_x) : f2_x;
    if (f_raw < f1_x)      f_clamp = F1;
    else if (f_raw > f2_x) f_clamp = F2;
    else                   f_clamp = f_raw[31:0];
  end

  assign sample   = data_valid && tr_mode_enable && (state == S_IDLE);
  assign start    = sample && !dead;
  assign div_last = (state == S_DIV) && (cnt == 5'd31);

  // Restoring divider: dividend bits shift out of quo as quotient bits shift in
  always_comb begin
    shifted = {rem[31:0], quo[31]};
    trial   = {1'b0, shifted} - {2'b0, dvsr};
    rem_nx  = trial[33] ? shifted : trial[32:0];
    quo_nx  = {quo[30:0], ~trial[33]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_DIV;
      S_DIV:  if (!tr_mode_enable || div_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drv_dir       <= 1'b0;
      drv_enable_sm <= 1'b0;
      N             <= '0;
      cnt           <= '0;
      rem           <= '0;
      quo           <= '0;
      dvsr          <= '0;
    end else if (!tr_mode_enable) begin
      drv_enable_sm <= 1'b0;
    end else if (sample) begin
      drv_dir <= !e[E_W-1] && (e != '0);
      if (dead) drv_enable_sm <= 1'b0;
      else begin
        cnt  <= '0;
        rem  <= '0;
        quo  <= 32'(CLK_HZ);
        dvsr <= f_clamp;
      end
    end else if (state == S_DIV) begin
      cnt <= cnt + 5'd1;
      rem <= rem_nx;
      quo <= quo_nx;
      if (div_last) begin
        N             <= (quo_nx > N_MAX) ? N_MAX[N_W-1:0] : quo_nx[N_W-1:0];
        drv_enable_sm <= 1'b1;
      end
    end
  end

  // Pulse stage: shadow N/enable only at a period boundary so a period never tears
  assign run = en_act && (n_act >= N_W'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      n_act    <= '0;
      en_act   <= 1'b0;
      counter  <= '0;
      drv_step <= 1'b0;
    end else if (!tr_mode_enable) begin
      en_act   <= 1'b0;
      counter  <= '0;
      drv_step <= 1'b0;
    end else begin
      if (data_valid_trig && counter == '0) begin
        n_act  <= N;
        en_act <= drv_enable_sm;
      end
      if (run) begin
        counter  <= (counter >= n_act - N_W'(1)) ? '0 : counter + N_W'(1);
        drv_step <= counter < (n_act >> 1);
      end else begin
        counter  <= '0;
        drv_step <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tr_track_drive.sv
// Directed bench for tr_track_drive: sample mapping, divider, pulse timing, disable, reset.
module tb_tr_track_drive;
  logic clk = 1'b0, rst, data_valid, data_valid_trig, tr_mode_enable;
  logic [35:0] x;
  logic [31:0] x0, dx1, dx2, k, F1, F2;
  logic drv_step, drv_dir, drv_enable_sm;
  logic [16:0] N;
  int compared = 0, mismatched = 0;

  tr_track_drive dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_valid_trig(data_valid_trig),
    .tr_mode_enable(tr_mode_enable), .x(x), .x0(x0), .dx1(dx1), .dx2(dx2), .k(k),
    .F1(F1), .F2(F2), .drv_step(drv_step), .drv_dir(drv_dir),
    .drv_enable_sm(drv_enable_sm), .N(N)
  );

  always #5 clk = ~clk;

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [35:0] v);
    x = v; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Leaves the bench at the first negedge with drv_step high after a low
  task automatic sync_rise(input int max, output bit ok);
    int t = 0;
    while (drv_step !== 1'b0 && t < max) begin t++; @(negedge clk); end
    while (drv_step !== 1'b1 && t < max) begin t++; @(negedge clk); end
    ok = (t < max);
  endtask

  task automatic run_len(input logic lvl, input int max, output int len);
    len = 0;
    while (drv_step === lvl && len < max) begin len++; @(negedge clk); end
  endtask

  task automatic test_reset;
    rst = 1'b1; clks(3);
    compared += 4;
    if (drv_step !== 1'b0) begin mismatched++; $display("FAIL reset_step got %b want 0", drv_step); end
    if (drv_dir !== 1'b0) begin mismatched++; $display("FAIL reset_dir got %b want 0", drv_dir); end
    if (drv_enable_sm !== 1'b0) begin mismatched++; $display("FAIL reset_en got %b want 0", drv_enable_sm); end
    if (N !== 17'd0) begin mismatched++; $display("FAIL reset_N got %0d want 0", N); end
    rst = 1'b0; clks(2);
  endtask

  task automatic test_saturate;
    bit ok; int hi, lo;
    send(36'd30000); clks(36);
    compared += 3;
    if (drv_dir !== 1'b1) begin mismatched++; $display("FAIL sat_dir got %b want 1", drv_dir); end
    if (drv_enable_sm !== 1'b1) begin mismatched++; $display("FAIL sat_en got %b want 1", drv_enable_sm); end
    if (N !== 17'd1000) begin mismatched++; $display("FAIL sat_N got %0d want 1000", N); end
    sync_rise(3000, ok);
    run_len(1'b1, 3000, hi); run_len(1'b0, 3000, lo);
    compared += 3;
    if (!ok) begin mismatched++; $display("FAIL sat_rise got timeout want edge"); end
    if (hi != 500) begin mismatched++; $display("FAIL sat_hi got %0d want 500", hi); end
    if (lo != 500) begin mismatched++; $display("FAIL sat_lo got %0d want 500", lo); end
  endtask

  task automatic test_ramp_wrap;
    bit ok; int hi0, lo0, hi1, lo1;
    sync_rise(3000, ok);
    x = 36'd3000; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0;
    run_len(1'b1, 3000, hi0); hi0++;
    run_len(1'b0, 3000, lo0);
    run_len(1'b1, 5000, hi1); run_len(1'b0, 5000, lo1);
    compared += 5;
    if (N !== 17'd3468) begin mismatched++; $display("FAIL ramp_N got %0d want 3468", N); end
    if (hi0 != 500) begin mismatched++; $display("FAIL ramp_old_hi got %0d want 500", hi0); end
    if (lo0 != 500) begin mismatched++; $display("FAIL ramp_old_lo got %0d want 500", lo0); end
    if (hi1 != 1734) begin mismatched++; $display("FAIL ramp_new_hi got %0d want 1734", hi1); end
    if (lo1 != 1734) begin mismatched++; $display("FAIL ramp_new_lo got %0d want 1734", lo1); end
  endtask

  task automatic test_dx1_and_dead;
    int bad = 0;
    send(36'd2505); clks(36);
    compared += 2;
    if (N !== 17'd8333) begin mismatched++; $display("FAIL dx1_N got %0d want 8333", N); end
    if (drv_enable_sm !== 1'b1) begin mismatched++; $display("FAIL dx1_en got %b want 1", drv_enable_sm); end
    send(36'd1000); clks(2);
    compared += 2;
    if (drv_enable_sm !== 1'b0) begin mismatched++; $display("FAIL dead_en got %b want 0", drv_enable_sm); end
    if (N !== 17'd8333) begin mismatched++; $display("FAIL dead_N_hold got %0d want 8333", N); end
    clks(8600);
    for (int i = 0; i < 20; i++) begin if (drv_step !== 1'b0) bad++; @(negedge clk); end
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL dead_step got %0d high cycles want 0", bad); end
  endtask

  task automatic test_negative;
    send(36'd0); clks(2);
    compared += 2;
    if (drv_dir !== 1'b0) begin mismatched++; $display("FAIL neg_dir got %b want 0", drv_dir); end
    if (drv_enable_sm !== 1'b0) begin mismatched++; $display("FAIL neg_en got %b want 0", drv_enable_sm); end
  endtask

  task automatic test_disable;
    bit ok; int hi, bad = 0;
    send(36'd30000); clks(36);
    sync_rise(3000, ok); clks(100);
    tr_mode_enable = 1'b0; x = 36'd0; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0;
    compared += 5;
    if (!ok) begin mismatched++; $display("FAIL dis_rise got timeout want edge"); end
    if (drv_step !== 1'b0) begin mismatched++; $display("FAIL dis_step got %b want 0", drv_step); end
    if (drv_enable_sm !== 1'b0) begin mismatched++; $display("FAIL dis_en got %b want 0", drv_enable_sm); end
    if (drv_dir !== 1'b1) begin mismatched++; $display("FAIL dis_dir_hold got %b want 1", drv_dir); end
    if (N !== 17'd1000) begin mismatched++; $display("FAIL dis_N_hold got %0d want 1000", N); end
    clks(10);
    tr_mode_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin if (drv_step !== 1'b0) bad++; @(negedge clk); end
    send(36'd30000); clks(36);
    sync_rise(3000, ok); run_len(1'b1, 3000, hi);
    compared += 3;
    if (bad != 0) begin mismatched++; $display("FAIL reen_idle got %0d high cycles want 0", bad); end
    if (!ok) begin mismatched++; $display("FAIL reen_rise got timeout want edge"); end
    if (hi != 500) begin mismatched++; $display("FAIL reen_hi got %0d want 500", hi); end
  endtask

  task automatic test_busy_drop;
    send(36'd3000); clks(4);
    send(36'd30000); clks(40);
    compared++;
    if (N !== 17'd3468) begin mismatched++; $display("FAIL busy_drop_N got %0d want 3468", N); end
  endtask

  task automatic test_clamp;
    F1 = 32'd100; F2 = 32'd300;
    send(36'd30000); clks(36);
    compared++;
    if (N !== 17'd131071) begin mismatched++; $display("FAIL clamp_N got %0d want 131071", N); end
    F1 = 32'd6000; F2 = 32'd50000;
  endtask

  task automatic test_reset_mid;
    bit ok;
    sync_rise(8000, ok);
    rst = 1'b1; @(negedge clk);
    compared += 5;
    if (!ok) begin mismatched++; $display("FAIL rstmid_rise got timeout want edge"); end
    if (drv_step !== 1'b0) begin mismatched++; $display("FAIL rstmid_step got %b want 0", drv_step); end
    if (drv_enable_sm !== 1'b0) begin mismatched++; $display("FAIL rstmid_en got %b want 0", drv_enable_sm); end
    if (drv_dir !== 1'b0) begin mismatched++; $display("FAIL rstmid_dir got %b want 0", drv_dir); end
    if (N !== 17'd0) begin mismatched++; $display("FAIL rstmid_N got %0d want 0", N); end
    rst = 1'b0; clks(2);
    send(36'd3000); clks(10);
    rst = 1'b1; @(negedge clk); rst = 1'b0; clks(40);
    compared += 3;
    if (N !== 17'd0) begin mismatched++; $display("FAIL rstdiv_N got %0d want 0", N); end
    if (drv_enable_sm !== 1'b0) begin mismatched++; $display("FAIL rstdiv_en got %b want 0", drv_enable_sm); end
    if (drv_step !== 1'b0) begin mismatched++; $display("FAIL rstdiv_step got %b want 0", drv_step); end
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_valid_trig = 1'b1; tr_mode_enable = 1'b1;
    x = '0; x0 = 32'd5; dx1 = 32'd2500; dx2 = 32'd5000; k = 32'd17;
    F1 = 32'd6000; F2 = 32'd50000;
    @(negedge clk);
    test_reset;
    test_saturate;
    test_ramp_wrap;
    test_dx1_and_dead;
    test_negative;
    test_disable;
    test_busy_drop;
    test_clamp;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
